serial_port: RTL

SERIAL_PORT -- requirements
Module: serial_port

---
 rtl/serial_port_pkg.sv | 40 ++++
 rtl/serial_fifo.sv | 59 +++++
 rtl/serial_port.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial port: register map, STATUS bit
// positions, FSM state encodings and the divisor clamp helper.
package serial_port_pkg;

    // Register select values on adrBusLo
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV_LO = 2'd2;
    localparam logic [1:0] REG_DIV_HI = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_RX_AVAIL    = 0;
    localparam int unsigned ST_TX_NOT_FULL = 1;
    localparam int unsigned ST_TX_BUSY     = 2;
    localparam int unsigned ST_RX_OVERRUN  = 3;
    localparam int unsigned ST_FRAME_ERR   = 4;

    // Shortest bit time the shifters will run at
    localparam logic [15:0] MIN_DIV = 16'd16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Bit time actually used for a programmed divisor
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i         write wdata_i; accepted when not full or when popping
//   pop_i          advance head; ignored when empty
//   wdata_i        data to push
//   rdata_o        current head entry (valid when !empty_o)
//   empty_o/full_o occupancy flags
module serial_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/serial_port.sv
// Memory-mapped 8N1 serial port with TX/RX FIFOs and programmable divisor.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   srlEn, rw         active-low select, read(1)/write(0)
//   adrBusLo, datIn   register select and write data
//   datOut, datOutEn  combinational read data and its drive enable
//   rxd, txd          serial input (asynchronous) and output, both idle high
//   irq               active-low, asserted while received data is waiting
module serial_port
    import serial_port_pkg::*;
#(
    parameter logic [15:0] DIV_RESET  = 16'd833,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srlEn,
    input  logic       rw,
    input  logic [1:0] adrBusLo,
    input  logic [7:0] datIn,
    output logic [7:0] datOut,
    output logic       datOutEn,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);

    logic        bus_wr, bus_rd, status_wr;
    logic [15:0] div_q;
    logic        rx_overrun_q, frame_err_q;

    assign bus_wr    = !srlEn && !rw;
    assign bus_rd    = !srlEn && rw;
    assign status_wr = bus_wr && (adrBusLo == REG_STATUS);
    assign datOutEn  = bus_rd;

    // ---------------- FIFOs ----------------
    logic       tx_pop, tx_empty, tx_full;
    logic [7:0] tx_head;
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0] rx_head;

    assign rx_pop = bus_rd && (adrBusLo == REG_DATA);

    serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk), .rst_i(rst),
        .push_i(bus_wr && (adrBusLo == REG_DATA)), .pop_i(tx_pop),
        .wdata_i(datIn), .rdata_o(tx_head),
        .empty_o(tx_empty), .full_o(tx_full)
    );

    // ---------------- TX ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_bitdiv_q, tx_bitdiv_d;
    logic [2:0]  tx_bitidx_q, tx_bitidx_d;
    logic [7:0]  tx_shreg_q, tx_shreg_d;
    logic        tx_bit_end;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q + 16'd1;
        tx_bitdiv_d = tx_bitdiv_q;
        tx_bitidx_d = tx_bitidx_q;
        tx_shreg_d  = tx_shreg_q;
        tx_pop      = 1'b0;
        txd         = 1'b1;
        tx_bit_end  = (tx_cnt_q == tx_bitdiv_q - 16'd1);
        // Divisor is re-latched at every bit boundary so writes take effect there
        if (tx_state_q != TX_IDLE && tx_bit_end) begin
            tx_cnt_d    = '0;
            tx_bitdiv_d = eff_div(div_q);
        end
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_shreg_d  = tx_head;
                    tx_bitdiv_d = eff_div(div_q);
                    tx_state_d  = TX_START;
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_bit_end) begin
                    tx_bitidx_d = '0;
                    tx_state_d  = TX_DATA;
                end
            end
            TX_DATA: begin
                txd = tx_shreg_q[0];
                if (tx_bit_end) begin
                    tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
                    if (tx_bitidx_q == 3'd7) tx_state_d  = TX_STOP;
                    else                     tx_bitidx_d = tx_bitidx_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shreg_d = tx_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // ---------------- RX ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_bitdiv_q, rx_bitdiv_d;
    logic [2:0]  rx_bitidx_q, rx_bitidx_d;
    logic [7:0]  rx_shreg_q, rx_shreg_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        rx_sample, rx_set_ovr, rx_set_ferr;

    serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk), .rst_i(rst),
        .push_i(rx_push), .pop_i(rx_pop),
        .wdata_i(rx_shreg_q), .rdata_o(rx_head),
        .empty_o(rx_empty), .full_o(rx_full)
    );

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_bitdiv_d = rx_bitdiv_q;
        rx_bitidx_d = rx_bitidx_q;
        rx_shreg_d  = rx_shreg_q;
        rx_push     = 1'b0;
        rx_set_ovr  = 1'b0;
        rx_set_ferr = 1'b0;
        // Start bit is checked at half a bit time, later bits one full bit apart
        rx_sample = (rx_state_q == RX_START)
                  ? (rx_cnt_q == {1'b0, rx_bitdiv_q[15:1]} - 16'd1)
                  : (rx_cnt_q == rx_bitdiv_q - 16'd1);
        if (rx_state_q != RX_IDLE && rx_sample) begin
            rx_cnt_d    = '0;
            rx_bitdiv_d = eff_div(div_q);
        end
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_bitdiv_d = eff_div(div_q);
                    rx_state_d  = RX_START;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_bitidx_d = '0;
                        rx_state_d  = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
                    if (rx_bitidx_q == 3'd7) rx_state_d  = RX_STOP;
                    else                     rx_bitidx_d = rx_bitidx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        rx_push    = 1'b1;
                        // A same-cycle CPU pop makes room, so no overrun then
                        rx_set_ovr = rx_full && !rx_pop;
                    end else begin
                        rx_set_ferr = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bitdiv_q  <= MIN_DIV;
            tx_bitidx_q  <= '0;
            tx_shreg_q   <= '0;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bitdiv_q  <= MIN_DIV;
            rx_bitidx_q  <= '0;
            rx_shreg_q   <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_q        <= DIV_RESET;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bitdiv_q  <= tx_bitdiv_d;
            tx_bitidx_q  <= tx_bitidx_d;
            tx_shreg_q   <= tx_shreg_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bitdiv_q  <= rx_bitdiv_d;
            rx_bitidx_q  <= rx_bitidx_d;
            rx_shreg_q   <= rx_shreg_d;
            rx_meta_q    <= rxd;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            if (bus_wr && adrBusLo == REG_DIV_LO) div_q[7:0]  <= datIn;
            if (bus_wr && adrBusLo == REG_DIV_HI) div_q[15:8] <= datIn;
            // A new error in the clearing cycle is kept
            rx_overrun_q <= (rx_overrun_q && !status_wr) || rx_set_ovr;
            frame_err_q  <= (frame_err_q  && !status_wr) || rx_set_ferr;
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        datOut = '0;
        case (adrBusLo)
            REG_DATA:   datOut = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: begin
                datOut[ST_RX_AVAIL]    = !rx_empty;
                datOut[ST_TX_NOT_FULL] = !tx_full;
                datOut[ST_TX_BUSY]     = (tx_state_q != TX_IDLE);
                datOut[ST_RX_OVERRUN]  = rx_overrun_q;
                datOut[ST_FRAME_ERR]   = frame_err_q;
            end
            REG_DIV_LO: datOut = div_q[7:0];
            default:    datOut = div_q[15:8];
        endcase
    end

    assign irq = rx_empty;

endmodule
